// File: rtl/grid_vga_renderer.sv
// 640x480@60 VGA renderer for a 16x16 occupancy board. The board image is taken
// from a shadow copy of grid_in latched once per frame, at the start of vertical blanking.
module grid_vga_renderer #(
    parameter int CELL_PX      = 24,
    parameter int ORIGIN_X     = 128,
    parameter int ORIGIN_Y     = 48,
    parameter int H_VISIBLE    = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_VISIBLE    = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [255:0] grid_in,
    output logic         hsync,
    output logic         vsync,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         frame_start
);
    localparam int PXW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [PXW-1:0] PX_LAST = PXW'(CELL_PX - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS0    = 10'(H_SYNC_START);
    localparam logic [9:0] HS1    = 10'(H_SYNC_END);
    localparam logic [9:0] VS0    = 10'(V_SYNC_START);
    localparam logic [9:0] VS1    = 10'(V_SYNC_END);
    localparam logic [9:0] BX0    = 10'(ORIGIN_X);
    localparam logic [9:0] BX1    = 10'(ORIGIN_X + 16 * CELL_PX);
    localparam logic [9:0] BY0    = 10'(ORIGIN_Y);
    localparam logic [9:0] BY1    = 10'(ORIGIN_Y + 16 * CELL_PX);

    logic [1:0]     div_q, div_d;
    logic [9:0]     hcount_q, hcount_d, vcount_q, vcount_d;
    logic [PXW-1:0] px_off_q, px_off_d, py_off_q, py_off_d;
    logic [3:0]     col_q, col_d, row_q, row_d;
    logic [255:0]   shadow_q, shadow_d;
    logic           hsync_q, hsync_d, vsync_q, vsync_d;
    logic           frame_start_q, frame_start_d;
    logic [11:0]    rgb_q, rgb_d;

    logic        pix_en, h_wrap, in_board_x, in_board_y, active, capture;
    logic [11:0] pixel_rgb;

    always_comb begin
        pix_en     = enable && (div_q == 2'd3);
        h_wrap     = (hcount_q == H_LAST);
        in_board_x = (hcount_q >= BX0) && (hcount_q < BX1);
        in_board_y = (vcount_q >= BY0) && (vcount_q < BY1);
        active     = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        capture    = pix_en && (hcount_q == '0) && (vcount_q == V_VIS);

        if (!active || !in_board_x || !in_board_y) begin
            pixel_rgb = 12'h000;
        end else if ((px_off_q == '0) || (py_off_q == '0)) begin
            pixel_rgb = 12'h333;
        end else if (shadow_q[{col_q, row_q}]) begin
            pixel_rgb = 12'h0F0;
        end else begin
            pixel_rgb = 12'h111;
        end
    end

    // Cell counters track the pixel currently addressed by hcount/vcount; col/row
    // saturate at 15 so the trailing edge of the board can never index past the grid.
    always_comb begin
        div_d         = enable ? (div_q + 2'd1) : div_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        px_off_d      = px_off_q;
        py_off_d      = py_off_q;
        col_d         = col_q;
        row_d         = row_q;
        shadow_d      = shadow_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = enable ? capture : frame_start_q;

        if (pix_en) begin
            hcount_d = h_wrap ? '0 : (hcount_q + 10'd1);
            if (h_wrap) begin
                px_off_d = '0;
                col_d    = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : (vcount_q + 10'd1);
                if (vcount_q == V_LAST) begin
                    py_off_d = '0;
                    row_d    = '0;
                end else if (in_board_y) begin
                    if (py_off_q == PX_LAST) begin
                        py_off_d = '0;
                        if (row_q != 4'd15) row_d = row_q + 4'd1;
                    end else begin
                        py_off_d = py_off_q + PXW'(1);
                    end
                end
            end else if (in_board_x) begin
                if (px_off_q == PX_LAST) begin
                    px_off_d = '0;
                    if (col_q != 4'd15) col_d = col_q + 4'd1;
                end else begin
                    px_off_d = px_off_q + PXW'(1);
                end
            end
            hsync_d = !((hcount_q >= HS0) && (hcount_q < HS1));
            vsync_d = !((vcount_q >= VS0) && (vcount_q < VS1));
            rgb_d   = pixel_rgb;
        end

        if (capture) shadow_d = grid_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            px_off_q      <= '0;
            py_off_q      <= '0;
            col_q         <= '0;
            row_q         <= '0;
            shadow_q      <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            px_off_q      <= px_off_d;
            py_off_q      <= py_off_d;
            col_q         <= col_d;
            row_q         <= row_d;
            shadow_q      <= shadow_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer: a shrunken-timing instance for frame-level rendering
// and capture behaviour, plus a default-timing instance for horizontal sync timing.
module tb_grid_vga_renderer;
    localparam int H_TOT = 48;
    localparam int V_TOT = 41;
    localparam int V_VIS = 36;
    localparam int FRAME = H_TOT * V_TOT;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [255:0] grid_in = '0;
    logic         hsync, vsync, frame_start;
    logic [3:0]   vga_r, vga_g, vga_b;
    logic         hsync_f, vsync_f, fs_f;
    logic [3:0]   r_f, g_f, b_f;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];
    int          exp_idx_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    grid_vga_renderer #(
        .CELL_PX(2), .ORIGIN_X(4), .ORIGIN_Y(2),
        .H_VISIBLE(40), .H_SYNC_START(42), .H_SYNC_END(46), .H_TOTAL(H_TOT),
        .V_VISIBLE(V_VIS), .V_SYNC_START(38), .V_SYNC_END(40), .V_TOTAL(V_TOT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
        .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    grid_vga_renderer dut_full (
        .clk(clk), .reset(reset), .enable(1'b1), .grid_in(256'd0),
        .hsync(hsync_f), .vsync(vsync_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
        .frame_start(fs_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [11:0] rgb);
        exp_idx_q.push_back(idx);
        exp_q.push_back(rgb);
    endtask

    // ---------------- monitor / scoreboard (small instance) ----------------
    int   div_m = 0, nh = 0, nv = 0, cur_h = 0, cur_v = 0, pix_idx = -1;
    logic presented;
    logic [13:0] prev_out;
    logic prev_fs;

    always begin
        @(posedge clk);
        #1;
        presented = 1'b0;
        if (!reset) begin
            div_m = 0; nh = 0; nv = 0; pix_idx = -1;
        end else begin
            if (enable) begin
                if (div_m == 3) begin
                    presented = 1'b1;
                    cur_h = nh;
                    cur_v = nv;
                    pix_idx++;
                    if (nh == H_TOT - 1) begin
                        nh = 0;
                        nv = (nv == V_TOT - 1) ? 0 : nv + 1;
                    end else begin
                        nh++;
                    end
                end
                div_m = (div_m + 1) % 4;
            end
            if (presented) begin
                check("hsync", hsync, !(cur_h >= 42 && cur_h < 46));
                check("vsync", vsync, !(cur_v >= 38 && cur_v < 40));
                check("frame_start", frame_start, (cur_h == 0 && cur_v == V_VIS));
                while (exp_idx_q.size() > 0 && exp_idx_q[0] < pix_idx) begin
                    check("probe_missed", pix_idx, exp_idx_q[0]);
                    void'(exp_idx_q.pop_front());
                    void'(exp_q.pop_front());
                end
                if (exp_idx_q.size() > 0 && exp_idx_q[0] == pix_idx) begin
                    check("pixel_rgb", {vga_r, vga_g, vga_b}, exp_q[0]);
                    void'(exp_idx_q.pop_front());
                    void'(exp_q.pop_front());
                end
            end else begin
                check("hold_outputs", {hsync, vsync, vga_r, vga_g, vga_b}, prev_out);
                check("frame_start_idle", frame_start, enable ? 1'b0 : prev_fs);
            end
        end
        prev_out = {hsync, vsync, vga_r, vga_g, vga_b};
        prev_fs  = frame_start;
    end

    // ---------------- hsync timing monitor (default-timing instance) ----------------
    int   cnt_f = 0, falls = 0, last_fall = 0;
    logic prev_hs_f = 1'b1;
    logic full_done = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            cnt_f = 0;
        end else if (!full_done) begin
            cnt_f++;
            if (prev_hs_f && !hsync_f) begin
                if (falls == 0) check("hsync_first_fall", cnt_f, 2628);
                else            check("hsync_period", cnt_f - last_fall, 3200);
                last_fall = cnt_f;
                falls++;
            end
            if (!prev_hs_f && hsync_f) begin
                check("hsync_low_width", cnt_f - last_fall, 384);
                if (falls == 3) full_done = 1'b1;
            end
        end
        prev_hs_f = hsync_f;
    end

    task automatic wait_pix(input int target);
        int guard = 0;
        while (pix_idx < target && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        if (pix_idx < target) check("wait_timeout", pix_idx, target);
    endtask

    // ---------------- driver ----------------
    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        grid_in = '0;
        repeat (3) @(negedge clk);
        check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("reset_hsync", hsync, 1'b1);
        check("reset_vsync", vsync, 1'b1);
        check("reset_frame_start", frame_start, 1'b0);
        check("full_reset_hsync", hsync_f, 1'b1);
        check("full_reset_vsync", vsync_f, 1'b1);

        // Frame 0 renders the empty shadow; frame 1 shows bit 0; frame 2 shows bit 255.
        push(0, 12'h000);
        push(2 * H_TOT + 4, 12'h333);
        push(3 * H_TOT + 5, 12'h111);
        push(10 * H_TOT + 40, 12'h000);
        push(FRAME + 2 * H_TOT + 4, 12'h333);
        push(FRAME + 3 * H_TOT + 5, 12'h0F0);
        push(FRAME + 3 * H_TOT + 6, 12'h333);
        push(FRAME + 5 * H_TOT + 5, 12'h111);
        push(FRAME + 33 * H_TOT + 35, 12'h111);
        push(2 * FRAME + 3 * H_TOT + 5, 12'h111);
        push(2 * FRAME + 5 * H_TOT + 11, 12'h111);
        push(2 * FRAME + 5 * H_TOT + 12, 12'h333);
        push(2 * FRAME + 33 * H_TOT + 35, 12'h0F0);
        push(2 * FRAME + 33 * H_TOT + 36, 12'h000);
        push(2 * FRAME + 34 * H_TOT + 35, 12'h000);

        grid_in = 256'd1;
        reset   = 1'b1;

        wait_pix(FRAME + 20 * H_TOT);
        grid_in = 256'd1 << 255;

        wait_pix(2 * FRAME + 5 * H_TOT + 10);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        enable = 1'b1;

        wait_pix(3 * FRAME + 30 * H_TOT + 10);
        check("queue_drained_a", exp_q.size(), 0);
        check("pre_reset_rgb", {vga_r, vga_g, vga_b}, 12'h333);
        reset = 1'b0;
        #1;
        check("mid_reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("mid_reset_hsync", hsync, 1'b1);
        check("mid_reset_vsync", vsync, 1'b1);
        check("mid_reset_frame_start", frame_start, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;

        // Shadow restarts empty even though grid_in still holds bit 255.
        push(2 * H_TOT + 4, 12'h333);
        push(3 * H_TOT + 5, 12'h111);
        push(33 * H_TOT + 35, 12'h111);
        push(FRAME + 33 * H_TOT + 35, 12'h0F0);
        wait_pix(FRAME + 33 * H_TOT + 40);

        check("queue_drained_b", exp_q.size(), 0);
        check("full_hsync_lines", falls, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
